whack_a_mole_fsm: RTL

Parametrised game controller for the switch/LED reaction game. It is the successor to the single-target reaction FSM. It owns its own on-time, gap and game-length timers, driven by a shared 1 ms tick. Level-dependent LED on-time has a floor. A lives counter is decremented on timeout or wrong switch. The block sits between the board switches/LEDs/start button and the score/level/lives seven-segment drivers.

---
 rtl/whack_pkg.sv | 33 +++
 rtl/whack_a_mole_fsm_countdown.sv | 42 ++++
 rtl/whack_a_mole_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole game controller and its display drivers.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SHOW,
        ST_HIT,
        ST_MISS,
        ST_OVER
    } state_t;

    localparam int MS_PER_SEC = 1000;

    // Display-driver widths for the default game configuration.
    localparam int LIVES_W = 3;
    localparam int SCORE_W = $clog2(99 + 1);
    localparam int LEVEL_W = $clog2(7 + 1);
    localparam int SECS_W  = $clog2(60 + 1);

    // Target on-time shrinks by step_ms per level but never drops below min_on.
    function automatic int on_time_ms(input int level, input int max_on, input int step_ms,
                                      input int min_on);
        int t;
        t = max_on - step_ms * level;
        return (t < min_on) ? min_on : t;
    endfunction

    function automatic logic is_playing(input state_t s);
        return (s == ST_GAP) || (s == ST_SHOW) || (s == ST_HIT) || (s == ST_MISS);
    endfunction

endpackage

// File: rtl/whack_a_mole_fsm_countdown.sv
// Game-length timer: 1 ms tick prescaler to seconds, counting down to zero.
module game_countdown import whack_pkg::*; #(
    parameter int GAME_S = 60,
    parameter int SECS_W = $clog2(GAME_S + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_ms,
    input  logic              load,
    input  logic              enable,
    output logic [SECS_W-1:0] secs_left,
    output logic              expired
);

    localparam int MS_W = $clog2(MS_PER_SEC);

    logic [MS_W-1:0]   ms_q;
    logic [SECS_W-1:0] secs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ms_q   <= '0;
            secs_q <= SECS_W'(GAME_S);
        end else if (load) begin
            ms_q   <= '0;
            secs_q <= SECS_W'(GAME_S);
        end else if (enable && tick_ms) begin
            if (ms_q == MS_W'(MS_PER_SEC - 1)) begin
                ms_q <= '0;
                if (secs_q != '0) begin
                    secs_q <= secs_q - SECS_W'(1);
                end
            end else begin
                ms_q <= ms_q + MS_W'(1);
            end
        end
    end

    assign secs_left = secs_q;
    assign expired   = enable && (secs_q == '0);

endmodule

// File: rtl/whack_a_mole_fsm.sv
// Whack-a-mole game controller: target selection, per-level on-time, score, level and lives.
module whack_a_mole_fsm import whack_pkg::*; #(
    parameter int LED_NUM         = 18,
    parameter int GAME_S          = 60,
    parameter int MAX_TIME_LED_ON = 1000,
    parameter int STEP_MS         = 200,
    parameter int MIN_ON_MS       = 200,
    parameter int GAP_MS          = 500,
    parameter int HITS_PER_LEVEL  = 5,
    parameter int MAX_LEVEL       = 7,
    parameter int LIVES           = 3,
    parameter int SCORE_MAX       = 99
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tick_ms,
    input  logic                               start,
    input  logic [$clog2(LED_NUM)-1:0]         random_value,
    input  logic [LED_NUM-1:0]                 switches,
    output logic [LED_NUM-1:0]                 led_on,
    output logic [$clog2(SCORE_MAX+1)-1:0]     score,
    output logic [$clog2(MAX_LEVEL+1)-1:0]     level,
    output logic [LIVES_W-1:0]                 lives_left,
    output logic [$clog2(GAME_S+1)-1:0]        secs_left,
    output logic                               playing,
    output logic                               game_over,
    output state_t                             state_dbg
);

    localparam int IDX_W   = $clog2(LED_NUM);
    localparam int SC_W    = $clog2(SCORE_MAX + 1);
    localparam int LV_W    = $clog2(MAX_LEVEL + 1);
    localparam int SE_W    = $clog2(GAME_S + 1);
    localparam int HIL_W   = $clog2(HITS_PER_LEVEL + 1);
    localparam int TMR_MAX = (MAX_TIME_LED_ON > GAP_MS) ?
                             ((MAX_TIME_LED_ON > MIN_ON_MS) ? MAX_TIME_LED_ON : MIN_ON_MS) :
                             ((GAP_MS > MIN_ON_MS) ? GAP_MS : MIN_ON_MS);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state_q, state_d;
    logic               start_q;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LED_NUM-1:0] snap_q, snap_d;
    logic [SC_W-1:0]    score_q, score_d;
    logic [LV_W-1:0]    level_q, level_d;
    logic [HIL_W-1:0]   hits_q, hits_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               playing_q, playing_d;
    logic               over_q, over_d;

    logic               start_edge, in_play, gc_load, gc_expired;
    logic [LED_NUM-1:0] target, toggled;
    logic [TMR_W-1:0]   on_time;
    logic [IDX_W-1:0]   idx_raw, idx_pick;

    assign start_edge = start && !start_q;
    assign in_play    = is_playing(state_q);
    assign target     = LED_NUM'(1) << idx_q;
    assign toggled    = switches ^ snap_q;
    assign on_time    = TMR_W'(on_time_ms(int'(level_q), MAX_TIME_LED_ON, STEP_MS, MIN_ON_MS));

    // random_value spans less than 2*LED_NUM, so one conditional subtract folds it into range.
    assign idx_raw  = (random_value >= IDX_W'(LED_NUM)) ? random_value - IDX_W'(LED_NUM)
                                                        : random_value;
    assign idx_pick = (idx_raw != idx_q) ? idx_raw :
                      (idx_raw == IDX_W'(LED_NUM - 1)) ? '0 : idx_raw + IDX_W'(1);

    game_countdown #(
        .GAME_S (GAME_S),
        .SECS_W (SE_W)
    ) u_countdown (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_ms   (tick_ms),
        .load      (gc_load),
        .enable    (in_play),
        .secs_left (secs_left),
        .expired   (gc_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        score_d = score_q;
        level_d = level_q;
        hits_d  = hits_q;
        lives_d = lives_q;
        gc_load = 1'b0;
        tmr_d   = tmr_q;

        if (in_play && start_edge) begin
            state_d = ST_IDLE;
        end else if (gc_expired) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_d = ST_GAP;
                        score_d = '0;
                        level_d = '0;
                        hits_d  = '0;
                        lives_d = LIVES_W'(LIVES);
                        gc_load = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick_ms && (tmr_q == TMR_W'(GAP_MS - 1))) begin
                        state_d = ST_SHOW;
                        idx_d   = idx_pick;
                        snap_d  = switches;
                    end
                end
                ST_SHOW: begin
                    // toggled == 0 (switch flipped back) is neither hit nor miss.
                    if (toggled == target) begin
                        state_d = ST_HIT;
                    end else if (|(toggled & ~target)) begin
                        state_d = ST_MISS;
                    end else if (tick_ms && (tmr_q == on_time - TMR_W'(1))) begin
                        state_d = ST_MISS;
                    end
                end
                ST_HIT: begin
                    state_d = ST_GAP;
                    if (score_q != SC_W'(SCORE_MAX)) begin
                        score_d = score_q + SC_W'(1);
                    end
                    if (hits_q == HIL_W'(HITS_PER_LEVEL - 1)) begin
                        hits_d = '0;
                        if (level_q != LV_W'(MAX_LEVEL)) begin
                            level_d = level_q + LV_W'(1);
                        end
                    end else begin
                        hits_d = hits_q + HIL_W'(1);
                    end
                end
                ST_MISS: begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_GAP;
                end
                ST_OVER: begin
                    if (start_edge) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tick_ms && ((state_q == ST_GAP) || (state_q == ST_SHOW))) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        led_d     = (state_d == ST_SHOW) ? (LED_NUM'(1) << idx_d) : '0;
        playing_d = is_playing(state_d);
        over_d    = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            tmr_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            score_q   <= '0;
            level_q   <= '0;
            hits_q    <= '0;
            lives_q   <= LIVES_W'(LIVES);
            led_q     <= '0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            score_q   <= score_d;
            level_q   <= level_d;
            hits_q    <= hits_d;
            lives_q   <= lives_d;
            led_q     <= led_d;
            playing_q <= playing_d;
            over_q    <= over_d;
        end
    end

    assign led_on     = led_q;
    assign score      = score_q;
    assign level      = level_q;
    assign lives_left = lives_q;
    assign playing    = playing_q;
    assign game_over  = over_q;
    assign state_dbg  = state_q;

endmodule
